counter_cmd_sequencer: RTL and testbench
========================================

// Module: counter_cmd_sequencer
// PURPOSE
//   Turns the active-low board push-buttons and the slide switches into
//   per-cycle command strobes for the lab up/down counter datapath.
//   The strobes are enable, direction, load, load value and clear.
//   Synchronises and debounces the keys, generates the count-rate tick, and
//   arbitrates between competing key requests with one priority FSM.
//   Sits between the board top-level I/O and the counter register.
// PARAMETERS
//   WIDTH      10   counter / switch width in bits
//   TICK_DIV   25   CLOCK_50 cycles per count tick (>=2); board build uses 50_000_000
//   DB_CYCLES  8    consecutive stable samples before a key level is accepted (>=1)
// PORTS
//   CLOCK_50      in   1      system clock, all logic rising-edge
//   reset         in   1      asynchronous, active-high; clears all state
//   key_n         in   3      raw buttons, active low: [0]=clear [1]=load [2]=count down
//   sw            in   WIDTH  raw switch value used as the load value
//   cnt_en        out  1      one-cycle pulse: counter steps by 1 this cycle
//   cnt_dir       out  1      1=up, 0=down; valid whenever cnt_en=1
//   cnt_load      out  1      level: counter takes cnt_load_val this cycle
//   cnt_load_val  out  WIDTH  registered copy of sw
//   cnt_clr       out  1      level: counter forced to 0 this cycle
//   state_o       out  2      current FSM state, for debug LEDs
// BEHAVIOUR
//   Reset: cnt_en=0, cnt_dir=1, cnt_load=0, cnt_load_val=0, cnt_clr=0, state_o=S_UP.
//     Debounced keys reset to released (1). Tick divider resets to 0.
//   Input path: key_n and sw each pass through a 2-flop synchroniser.
//     The debouncer per key counts identical synchronised samples.
//     Its output flips when DB_CYCLES agree; any disagreement restarts the count.
//     Raw press held stable -> command visible on outputs exactly DB_CYCLES+3 cycles later.
//     Glitches shorter than DB_CYCLES cycles never reach the FSM.
//   Tick: divider counts 0..TICK_DIV-1 and wraps; tick=1 on the cycle count==TICK_DIV-1.
//     Divider runs only in S_UP/S_DOWN. It is held at 0 in S_LOAD/S_CLEAR.
//     So the first step after leaving LOAD/CLEAR comes a full TICK_DIV cycles later.
//   FSM states: S_UP=0, S_DOWN=1, S_LOAD=2, S_CLEAR=3.
//     The next state is a pure function of the debounced keys.
//     Priority is clear > load > down > up.
//     clr pressed -> S_CLEAR; else load pressed -> S_LOAD; else down pressed -> S_DOWN.
//     Otherwise -> S_UP.
//     Transitions are allowed from any state to any state in one cycle.
//   Outputs are registered and are a function of the current state:
//     S_UP:    cnt_en=tick, cnt_dir=1
//     S_DOWN:  cnt_en=tick, cnt_dir=0
//     S_LOAD:  cnt_load=1 every cycle, cnt_load_val tracks the synchronised sw.
//       A sw change while the key is held reaches the counter 3 cycles later.
//     S_CLEAR: cnt_clr=1 every cycle.
//     Outside S_LOAD, cnt_load_val holds its last value.
//   Mutual exclusion: at most one of cnt_en, cnt_load, cnt_clr is 1 in any cycle.
//   cnt_dir only changes on cycles where cnt_en=0. Direction cannot change mid-pulse.
//   Simultaneous keys are resolved by priority alone. No latching or queuing of a lower key.
//   Releasing a higher key while a lower one is held goes directly to the lower-key state.
//   Count wrap-around is owned by the counter, not this block.
//   Reset asserted mid-operation forces the reset values asynchronously.
//     The first command after reset release requires a fresh debounce interval.
// STRUCTURE
//   Package counter_cmd_pkg:
//     - typedef enum logic [1:0] state_t {S_UP, S_DOWN, S_LOAD, S_CLEAR}
//     - key index constants KEY_CLR=0, KEY_LOAD=1, KEY_DOWN=2
//   Sub-module key_debounce holds the synchroniser, stable counter and debounced output.
//     It has parameter DB_CYCLES and is instantiated 3 times.
//   The tick divider and FSM stay inline.
// TESTING
//   1. Reset, all keys high, TICK_DIV=25.
//      -> cnt_en pulses every 25 cycles with cnt_dir=1; cnt_load and cnt_clr stay 0.
//   2. key_n=3'b011 held 5000 ns.
//      -> state_o=S_DOWN DB_CYCLES+3 cycles after the edge; pulses every 25 cycles with cnt_dir=0.
//   3. key_n=3'b101, then sw=234 after 100 ns.
//      -> cnt_load=1 continuously; cnt_load_val=234 three cycles after the sw change.
//      -> On release, the first cnt_en (up) comes 25 cycles after the state returns to S_UP.
//   4. key_n=3'b000 (all pressed).
//      -> state_o=S_CLEAR, cnt_clr=1, cnt_en=0, cnt_load=0.
//      -> Releasing key[0] only -> S_LOAD on the next debounced cycle.
//   5. key_n[2] glitch low for DB_CYCLES-1 cycles.
//      -> no state change, cnt_dir stays 1.
//   6. Assert reset for 1 cycle while in S_DOWN mid-divide.
//      -> All outputs at reset values immediately.
//      -> The divider restarts: first cnt_en comes 25 cycles after release.
//   All scenarios: assert that cnt_en, cnt_load and cnt_clr are never high together.

Source files
------------

// File: rtl/counter_cmd_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// counter_cmd_pkg
//   Shared types and constants for the counter command sequencer.
//   - state_t   : priority FSM state encoding (also driven onto debug LEDs)
//   - KEY_*     : bit index of each push-button inside key_n
//   - is_run()  : true for the states in which the counter is allowed to step
// ----------------------------------------------------------------------------
package counter_cmd_pkg;

    typedef enum logic [1:0] {
        S_UP    = 2'd0,
        S_DOWN  = 2'd1,
        S_LOAD  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    localparam int KEY_CLR  = 0;
    localparam int KEY_LOAD = 1;
    localparam int KEY_DOWN = 2;

    function automatic logic is_run(input state_t s);
        return (s == S_UP) || (s == S_DOWN);
    endfunction

endpackage

// File: rtl/counter_cmd_sequencer_key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
//   Synchronises one raw active-low button into the clock domain and only
//   accepts a new level after DB_CYCLES consecutive identical samples.
//   Ports:
//     clk      in  system clock
//     rst      in  asynchronous active-high reset (output returns to released)
//     key_raw  in  raw button level, asynchronous to clk
//     key_db   out debounced level, 1 = released
// ----------------------------------------------------------------------------
module key_debounce #(
    parameter int DB_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_db
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic [CW-1:0] cnt_r;

    // Two-flop synchroniser followed by the stable-sample counter. The counter
    // only advances while the synchronised level differs from the accepted one;
    // because the key is a single bit, every differing sample is the same value,
    // so a run of DB_CYCLES differing samples is a run of identical samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            cnt_r   <= '0;
            key_db  <= 1'b1;
        end else begin
            sync1_r <= key_raw;
            sync2_r <= sync1_r;
            if (sync2_r == key_db) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                key_db <= sync2_r;
                cnt_r  <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// counter_cmd_sequencer
//   Converts board push-buttons and slide switches into per-cycle command
//   strobes for the up/down counter: step enable + direction, load + value,
//   and clear. One priority FSM (clear > load > down > up) picks the command.
//   Ports:
//     CLOCK_50      in  system clock
//     reset         in  asynchronous active-high reset
//     key_n[2:0]    in  raw buttons, active low: [0] clear, [1] load, [2] down
//     sw            in  raw switch value used as load value
//     cnt_en        out one-cycle step pulse at the tick rate (S_UP/S_DOWN)
//     cnt_dir       out 1 = up, 0 = down; meaningful while cnt_en = 1
//     cnt_load      out level, high in S_LOAD
//     cnt_load_val  out synchronised switch value captured while in S_LOAD
//     cnt_clr       out level, high in S_CLEAR
//     state_o       out current FSM state for debug LEDs
// ----------------------------------------------------------------------------
module counter_cmd_sequencer
    import counter_cmd_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int TICK_DIV  = 25,
    parameter int DB_CYCLES = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [2:0]       key_n,
    input  logic [WIDTH-1:0] sw,
    output logic             cnt_en,
    output logic             cnt_dir,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             cnt_clr,
    output logic [1:0]       state_o
);

    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic [2:0]       key_db_s;
    logic [WIDTH-1:0] sw_sync1_r;
    logic [WIDTH-1:0] sw_sync2_r;
    state_t           state_r;
    state_t           next_state_s;
    logic [DW-1:0]    div_r;
    logic [DW-1:0]    div_next_s;
    logic             tick_s;
    logic             en_next_s;
    logic             dir_next_s;
    logic [WIDTH-1:0] load_val_next_s;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_db
            key_debounce #(
                .DB_CYCLES (DB_CYCLES)
            ) u_db (
                .clk     (CLOCK_50),
                .rst     (reset),
                .key_raw (key_n[g]),
                .key_db  (key_db_s[g])
            );
        end
    endgenerate

    // Switch synchroniser; no debounce, the value is only sampled in S_LOAD.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sw_sync1_r <= '0;
            sw_sync2_r <= '0;
        end else begin
            sw_sync1_r <= sw;
            sw_sync2_r <= sw_sync1_r;
        end
    end

    // Priority next-state decode from the debounced keys (pressed = 0).
    always_comb begin
        next_state_s = S_UP;
        if (!key_db_s[KEY_CLR]) begin
            next_state_s = S_CLEAR;
        end else if (!key_db_s[KEY_LOAD]) begin
            next_state_s = S_LOAD;
        end else if (!key_db_s[KEY_DOWN]) begin
            next_state_s = S_DOWN;
        end else begin
            next_state_s = S_UP;
        end
    end

    // Divider and strobe decode. The divider restarts from 0 whenever the
    // counting modes are entered, so the first step after LOAD/CLEAR is a full
    // tick period away. A step due on a cycle where the state changes is
    // dropped so the direction never changes together with a pulse.
    always_comb begin
        tick_s          = (div_r == DIV_LAST);
        div_next_s      = '0;
        en_next_s       = 1'b0;
        dir_next_s      = cnt_dir;
        load_val_next_s = cnt_load_val;
        if (is_run(state_r) && is_run(next_state_s)) begin
            div_next_s = tick_s ? '0 : (div_r + DW'(1));
            en_next_s  = tick_s && (next_state_s == state_r);
        end else begin
            div_next_s = '0;
            en_next_s  = 1'b0;
        end
        case (next_state_s)
            S_UP:    dir_next_s = 1'b1;
            S_DOWN:  dir_next_s = 1'b0;
            S_LOAD:  load_val_next_s = sw_sync2_r;
            S_CLEAR: dir_next_s = cnt_dir;
            default: dir_next_s = cnt_dir;
        endcase
    end

    // State, divider and registered command outputs, all updated together so
    // state_o and the strobes it implies change on the same edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r      <= S_UP;
            div_r        <= '0;
            cnt_en       <= 1'b0;
            cnt_dir      <= 1'b1;
            cnt_load     <= 1'b0;
            cnt_load_val <= '0;
            cnt_clr      <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            div_r        <= div_next_s;
            cnt_en       <= en_next_s;
            cnt_dir      <= dir_next_s;
            cnt_load     <= (next_state_s == S_LOAD);
            cnt_load_val <= load_val_next_s;
            cnt_clr      <= (next_state_s == S_CLEAR);
        end
    end

    assign state_o = state_r;

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_counter_cmd_sequencer
//   Directed scenarios with hand-computed timing, plus a per-cycle reference
//   model built from the behavioural rules (sample history windows for the
//   debounce, a cycles-in-run-mode count for the tick).
// ----------------------------------------------------------------------------
module tb_counter_cmd_sequencer;

    localparam int W  = 10;
    localparam int T  = 25;
    localparam int DB = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   key_n;
    logic [W-1:0] sw;
    logic         cnt_en, cnt_dir, cnt_load, cnt_clr;
    logic [W-1:0] cnt_load_val;
    logic [1:0]   state_o;

    int checks = 0;
    int errors = 0;

    counter_cmd_sequencer #(.WIDTH(W), .TICK_DIV(T), .DB_CYCLES(DB)) dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .key_n        (key_n),
        .sw           (sw),
        .cnt_en       (cnt_en),
        .cnt_dir      (cnt_dir),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .cnt_clr      (cnt_clr),
        .state_o      (state_o)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [2:0]   hk [0:DB+1];   // hk[k] = key_n present k edges ago
    logic [W-1:0] hs [0:2];
    logic [2:0]   mdb;
    int           mstate, p;
    bit           men, mdir;
    logic [W-1:0] mlv;

    function automatic int prio(input logic [2:0] db);
        if (!db[0]) return 3;
        if (!db[1]) return 2;
        if (!db[2]) return 1;
        return 0;
    endfunction

    function automatic bit run(input int s);
        return (s == 0) || (s == 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k <= DB + 1; k++) hk[k] = 3'b111;
        for (int k = 0; k < 3; k++) hs[k] = '0;
        mdb = 3'b111; mstate = 0; p = 0; men = 1'b0; mdir = 1'b1; mlv = '0;
    endtask

    always begin
        int old;
        bit ok, both;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            for (int k = DB + 1; k > 0; k--) hk[k] = hk[k-1];
            hk[0] = key_n;
            hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = sw;
            old    = mstate;
            mstate = prio(mdb);
            // a key level is accepted once DB synchronised samples all agree
            for (int b = 0; b < 3; b++) begin
                ok = 1'b1;
                for (int k = 3; k <= DB + 1; k++) if (hk[k][b] != hk[2][b]) ok = 1'b0;
                if (ok) mdb[b] = hk[2][b];
            end
            both = run(old) && run(mstate);
            p    = both ? p + 1 : 0;
            men  = both && (old == mstate) && (p % T == 0);
            if (run(mstate)) mdir = (mstate == 0);
            if (mstate == 2) mlv = hs[2];
        end
        #1;
        chk("state_o", int'(state_o), mstate);
        chk("cnt_en", int'(cnt_en), int'(men));
        chk("cnt_load", int'(cnt_load), int'(mstate == 2));
        chk("cnt_clr", int'(cnt_clr), int'(mstate == 3));
        chk("cnt_load_val", int'(cnt_load_val), int'(mlv));
        if (men) chk("cnt_dir", int'(cnt_dir), int'(mdir));
        chk("mutex", ((int'(cnt_en) + int'(cnt_load) + int'(cnt_clr)) > 1) ? 1 : 0, 0);
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_state(input logic [1:0] s, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (state_o != s && n < 300);
    endtask

    task automatic wait_en(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!cnt_en && n < 300);
    endtask

    initial begin
        int n, bad, sdown;
        reset = 1'b1; key_n = 3'b111; sw = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: idle counting up
        wait_en(n);  chk("s1_first_en", n, T);
        wait_en(n);  chk("s1_period", n, T);
        chk("s1_dir", int'(cnt_dir), 1);

        // 2: count down held
        key_n = 3'b011;
        wait_state(2'd1, n); chk("s2_latency", n, DB + 3);
        wait_en(n);
        wait_en(n);  chk("s2_period", n, T);
        chk("s2_dir", int'(cnt_dir), 0);
        repeat (180) @(negedge clk);
        key_n = 3'b111;
        wait_state(2'd0, n); chk("s2_release", n, DB + 3);

        // 3: load with switch change while held
        key_n = 3'b101;
        repeat (5) @(negedge clk);
        sw = 10'd100;
        wait_state(2'd2, n); chk("s3_to_load", n, DB + 3 - 5);
        chk("s3_first_val", int'(cnt_load_val), 100);
        sw = 10'd234;
        repeat (2) @(negedge clk);
        chk("s3_val_not_yet", int'(cnt_load_val), 100);
        @(negedge clk);
        chk("s3_val_3cyc", int'(cnt_load_val), 234);
        repeat (10) @(negedge clk);
        chk("s3_load_level", int'(cnt_load), 1);
        key_n = 3'b111;
        wait_state(2'd0, n); chk("s3_release", n, DB + 3);
        wait_en(n);  chk("s3_first_up", n, T);
        chk("s3_dir", int'(cnt_dir), 1);

        // 4: all keys pressed, then clear released
        key_n = 3'b000;
        wait_state(2'd3, n); chk("s4_to_clear", n, DB + 3);
        chk("s4_clr", int'(cnt_clr), 1);
        chk("s4_en", int'(cnt_en), 0);
        chk("s4_load", int'(cnt_load), 0);
        key_n = 3'b001;
        wait_state(2'd2, n); chk("s4_to_load", n, DB + 3);
        key_n = 3'b111;
        wait_state(2'd0, n); chk("s4_release", n, DB + 3);

        // 5: short glitch on the down key
        repeat (3) @(negedge clk);
        key_n = 3'b011;
        repeat (DB - 1) @(negedge clk);
        key_n = 3'b111;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (state_o != 2'd0 || cnt_dir != 1'b1) bad++;
        end
        chk("s5_glitch", bad, 0);

        // 6: reset mid-divide in S_DOWN
        key_n = 3'b011;
        wait_state(2'd1, n); chk("s6_to_down", n, DB + 3);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("s6_rst_en", int'(cnt_en), 0);
        chk("s6_rst_dir", int'(cnt_dir), 1);
        chk("s6_rst_load", int'(cnt_load), 0);
        chk("s6_rst_val", int'(cnt_load_val), 0);
        chk("s6_rst_clr", int'(cnt_clr), 0);
        chk("s6_rst_state", int'(state_o), 0);
        @(negedge clk);
        reset = 1'b0;
        n = 0; sdown = 0;
        do begin
            @(negedge clk); n++;
            if (state_o == 2'd1 && sdown == 0) sdown = n;
        end while (!cnt_en && n < 300);
        chk("s6_redebounce", sdown, DB + 3);
        chk("s6_first_en", n, T);
        chk("s6_dir", int'(cnt_dir), 0);
        key_n = 3'b111;
        wait_state(2'd0, n); chk("s6_release", n, DB + 3);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
